// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_defs (package)
// Description : Shared MIPS encodings used by the memory/write-back stage:
//               load opcodes, the syscall instruction word and the nop word.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_defs;

  // Primary opcodes (instruction bits [31:26]) of the load family
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;

  // Full syscall instruction word and the all-zero nop/bubble word
  localparam logic [31:0] SYSCALL_WORD = 32'h0000000C;
  localparam logic [31:0] NOP_WORD     = 32'h00000000;

endpackage : mips_defs
`default_nettype wire

// File: rtl/mem_wb_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational little-endian load-data alignment. Picks the
//               addressed byte/halfword out of the read word and sign- or
//               zero-extends it; non-load instructions pass the ALU result.
// Ports       : opcode  - instruction bits [31:26]
//               lane    - byte lane, effective address bits [1:0]
//               rdata   - word read from data memory (word-aligned address)
//               alu     - ALU result / effective address
//               aligned - register-file write data
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
  import mips_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [5:0]       opcode,
  input  logic [1:0]       lane,
  input  logic [WIDTH-1:0] rdata,
  input  logic [WIDTH-1:0] alu,
  output logic [WIDTH-1:0] aligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[{lane, 3'b000} +: 8];
    // Halfword selection only looks at lane[1]; an odd address is tolerated.
    w_half = lane[1] ? rdata[31:16] : rdata[15:0];

    case (opcode)
      OP_LW:   aligned = rdata;
      OP_LB:   aligned = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  aligned = {24'h000000, w_byte};
      OP_LH:   aligned = {{16{w_half[15]}}, w_half};
      OP_LHU:  aligned = {16'h0000, w_half};
      default: aligned = alu;
    endcase
  end

endmodule : load_align
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : Memory-to-write-back pipeline register with load alignment,
//               stall / flush-to-bubble control and a sticky RUN/HALTED FSM
//               entered on a syscall with $v0 == HALT_CODE.
// Ports       : clk, rst (sync, active high), stall, flush
//               m_*        - memory-stage instruction fields
//               Order .. LO_Write_to_GPR, wb_valid - registered WB fields
//               halted     - core halted (sticky until rst)
//               retire_cnt - retired-instruction count
// Options     : MEM_WB_RETIRE_CNT_EN - build the retire counter; when
//               undefined retire_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage
  import mips_defs::*;
#(
  parameter int WIDTH     = 32,
  parameter int HALT_CODE = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             m_valid,
  input  logic [WIDTH-1:0] m_order,
  input  logic [WIDTH-1:0] m_pc,
  input  logic [WIDTH-1:0] m_alu,
  input  logic [WIDTH-1:0] m_rdata,
  input  logic [WIDTH-1:0] m_hi,
  input  logic [4:0]       m_wreg,
  input  logic             m_reg_we,
  input  logic             m_hilo_we,
  input  logic             m_hi2gpr,
  input  logic             m_lo2gpr,
  input  logic [WIDTH-1:0] m_v0,
  output logic [WIDTH-1:0] Order,
  output logic [WIDTH-1:0] PC_out,
  output logic [WIDTH-1:0] RegFile_Din,
  output logic [WIDTH-1:0] HI_in,
  output logic [4:0]       Write_Reg_num,
  output logic             Reg_Write_enable,
  output logic             HI_LO_Write_enable,
  output logic             HI_Write_to_GPR,
  output logic             LO_Write_to_GPR,
  output logic             wb_valid,
  output logic             halted,
  output logic [WIDTH-1:0] retire_cnt
);

  localparam logic [0:0]       S_RUN    = 1'b0;
  localparam logic [0:0]       S_HALTED = 1'b1;
  localparam logic [WIDTH-1:0] c_halt   = WIDTH'(HALT_CODE);

  logic [0:0]       r_state;
  logic [0:0]       w_state_next;
  logic [WIDTH-1:0] w_aligned;
  logic             w_load;
  logic             w_halt_hit;
  logic             w_en;

  logic [WIDTH-1:0] r_order, r_pc, r_din, r_hi;
  logic [4:0]       r_wreg;
  logic             r_reg_we, r_hilo_we, r_hi2gpr, r_lo2gpr, r_valid;

  load_align #(.WIDTH(WIDTH)) u_load_align (
    .opcode  (m_order[31:26]),
    .lane    (m_alu[1:0]),
    .rdata   (m_rdata),
    .alu     (m_alu),
    .aligned (w_aligned)
  );

  // A loading edge needs no flush, no stall and a running core; rst is
  // handled ahead of this in every register process.
  assign w_load     = !flush && !stall && (r_state == S_RUN);
  assign w_halt_hit = w_load && m_valid && (m_order == SYSCALL_WORD)
                      && (m_v0 == c_halt);
  // The halting syscall retires as a valid slot that writes nothing.
  assign w_en       = m_valid && !w_halt_hit;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    if ((r_state == S_RUN) && w_halt_hit) w_state_next = S_HALTED;
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    halted = (r_state == S_HALTED);
  end

  // ---------------- pipeline register ----------------
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_order   <= NOP_WORD;
      r_pc      <= '0;
      r_din     <= '0;
      r_hi      <= '0;
      r_wreg    <= '0;
      r_reg_we  <= 1'b0;
      r_hilo_we <= 1'b0;
      r_hi2gpr  <= 1'b0;
      r_lo2gpr  <= 1'b0;
      r_valid   <= 1'b0;
    end else if (w_load) begin
      r_order   <= m_order;
      r_pc      <= m_pc;
      r_din     <= w_aligned;
      r_hi      <= m_hi;
      r_wreg    <= m_wreg;
      r_reg_we  <= m_reg_we && w_en;
      r_hilo_we <= m_hilo_we && w_en;
      r_hi2gpr  <= m_hi2gpr;
      r_lo2gpr  <= m_lo2gpr;
      r_valid   <= m_valid;
    end
  end

  assign Order              = r_order;
  assign PC_out             = r_pc;
  assign RegFile_Din        = r_din;
  assign HI_in              = r_hi;
  assign Write_Reg_num      = r_wreg;
  assign Reg_Write_enable   = r_reg_we;
  assign HI_LO_Write_enable = r_hilo_we;
  assign HI_Write_to_GPR    = r_hi2gpr;
  assign LO_Write_to_GPR    = r_lo2gpr;
  assign wb_valid           = r_valid;

  // ---------------- retire counter ----------------
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [WIDTH-1:0] r_retire_cnt;

  always_ff @(posedge clk) begin
    if (rst)                     r_retire_cnt <= '0;
    else if (w_load && m_valid)  r_retire_cnt <= r_retire_cnt + 1'b1;
  end

  assign retire_cnt = r_retire_cnt;
`else
  assign retire_cnt = '0;
`endif

endmodule : mem_wb_stage
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Self-checking bench for mem_wb_stage. The driver applies
//               directed and random stimulus on the falling edge and pushes
//               the expected post-edge register image into a queue; the
//               monitor pops one entry after every rising edge and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

  typedef struct {
    logic [31:0] order, pc, din, hi, cnt;
    logic [4:0]  wreg;
    logic        rwe, hlwe, h2, l2, wbv, halted;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush, m_valid;
  logic [31:0] m_order, m_pc, m_alu, m_rdata, m_hi, m_v0;
  logic [4:0]  m_wreg;
  logic        m_reg_we, m_hilo_we, m_hi2gpr, m_lo2gpr;

  logic [31:0] Order, PC_out, RegFile_Din, HI_in, retire_cnt;
  logic [4:0]  Write_Reg_num;
  logic        Reg_Write_enable, HI_LO_Write_enable, HI_Write_to_GPR;
  logic        LO_Write_to_GPR, wb_valid, halted;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t model;
  exp_t sb_q[$];
  bit   done = 1'b0;

  always #5 clk = ~clk;

  mem_wb_stage #(.WIDTH(32), .HALT_CODE(10)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_order(m_order), .m_pc(m_pc), .m_alu(m_alu),
    .m_rdata(m_rdata), .m_hi(m_hi), .m_wreg(m_wreg), .m_reg_we(m_reg_we),
    .m_hilo_we(m_hilo_we), .m_hi2gpr(m_hi2gpr), .m_lo2gpr(m_lo2gpr),
    .m_v0(m_v0), .Order(Order), .PC_out(PC_out), .RegFile_Din(RegFile_Din),
    .HI_in(HI_in), .Write_Reg_num(Write_Reg_num),
    .Reg_Write_enable(Reg_Write_enable), .HI_LO_Write_enable(HI_LO_Write_enable),
    .HI_Write_to_GPR(HI_Write_to_GPR), .LO_Write_to_GPR(LO_Write_to_GPR),
    .wb_valid(wb_valid), .halted(halted), .retire_cnt(retire_cnt)
  );

  // Reference load alignment from the ISA description: shift the word right
  // by the lane and mask, then extend.
  function automatic logic [31:0] ref_align(logic [31:0] order, logic [31:0] alu,
                                            logic [31:0] rdata);
    int unsigned op, lane, b, h;
    op   = order >> 26;
    lane = alu % 4;
    b    = (rdata >> (8 * lane)) & 255;
    h    = ((alu & 2) != 0) ? (rdata >> 16) : (rdata & 65535);
    case (op)
      35:      return rdata;
      32:      return (b >= 128) ? (b + 32'hFFFFFF00) : b;
      36:      return b;
      33:      return (h >= 32768) ? (h + 32'hFFFF0000) : h;
      37:      return h;
      default: return alu;
    endcase
  endfunction

  // Drive the current stimulus for one cycle and predict the next state.
  task automatic cycle();
    bit hit;
    exp_t n;
    n = model;
    if (rst) begin
      n = '{default: '0};
    end else if (flush) begin
      n.order = 0; n.pc = 0; n.din = 0; n.hi = 0; n.wreg = 0;
      n.rwe = 0; n.hlwe = 0; n.h2 = 0; n.l2 = 0; n.wbv = 0;
    end else if (!model.halted && !stall) begin
      hit = m_valid && (m_order == 32'h0000000C) && (m_v0 == 32'd10);
      n.order = m_order;
      n.pc    = m_pc;
      n.din   = ref_align(m_order, m_alu, m_rdata);
      n.hi    = m_hi;
      n.wreg  = m_wreg;
      n.rwe   = m_reg_we  && m_valid && !hit;
      n.hlwe  = m_hilo_we && m_valid && !hit;
      n.h2    = m_hi2gpr;
      n.l2    = m_lo2gpr;
      n.wbv   = m_valid;
      if (hit) n.halted = 1'b1;
`ifdef MEM_WB_RETIRE_CNT_EN
      if (m_valid) n.cnt = model.cnt + 32'd1;
`endif
    end
    model = n;
    sb_q.push_back(n);
    @(negedge clk);
  endtask

  task automatic set_idle();
    rst = 0; stall = 0; flush = 0; m_valid = 0;
    m_order = 0; m_pc = 0; m_alu = 0; m_rdata = 0; m_hi = 0; m_v0 = 0;
    m_wreg = 0; m_reg_we = 0; m_hilo_we = 0; m_hi2gpr = 0; m_lo2gpr = 0;
  endtask

  task automatic rand_fields();
    logic [5:0] ops [7];
    ops = '{6'b100011, 6'b100000, 6'b100100, 6'b100001, 6'b100101, 6'b000000, 6'b001001};
    m_order   = {ops[$urandom_range(6)], 26'($urandom)};
    m_pc      = $urandom & 32'hFFFFFFFC;
    m_alu     = $urandom;
    m_rdata   = $urandom;
    m_hi      = $urandom;
    m_wreg    = 5'($urandom);
    m_reg_we  = 1'($urandom);
    m_hilo_we = 1'($urandom);
    m_hi2gpr  = 1'($urandom);
    m_lo2gpr  = 1'($urandom);
    m_v0      = $urandom_range(15);
    m_valid   = ($urandom_range(3) != 0);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every register update is compared one edge after it was issued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("Order",        Order,              e.order);
        chk("PC_out",       PC_out,             e.pc);
        chk("RegFile_Din",  RegFile_Din,        e.din);
        chk("HI_in",        HI_in,              e.hi);
        chk("Write_Reg",    32'(Write_Reg_num), 32'(e.wreg));
        chk("Reg_WE",       32'(Reg_Write_enable),   32'(e.rwe));
        chk("HILO_WE",      32'(HI_LO_Write_enable), 32'(e.hlwe));
        chk("HI2GPR",       32'(HI_Write_to_GPR),    32'(e.h2));
        chk("LO2GPR",       32'(LO_Write_to_GPR),    32'(e.l2));
        chk("wb_valid",     32'(wb_valid),      32'(e.wbv));
        chk("halted",       32'(halted),        32'(e.halted));
        chk("retire_cnt",   retire_cnt,         e.cnt);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    model = '{default: '0};
    set_idle();
    @(negedge clk);

    // Reset for two cycles
    rst = 1; cycle(); cycle(); rst = 0;

    // lb / lbu from lane 1
    m_valid = 1; m_order = 32'h80020003; m_alu = 32'h1001; m_rdata = 32'h1234F678;
    m_reg_we = 1; m_wreg = 2; m_pc = 32'h400000;
    cycle();
    m_order = 32'h90020003; m_pc = 32'h400004; cycle();
    // lh / lhu upper half
    m_order = 32'h84020002; m_alu = 32'h1002; m_rdata = 32'h8001ABCD; cycle();
    m_order = 32'h94020002; cycle();
    // addu then stall with changing inputs
    m_order = 32'h00221821; m_alu = 32'd5; m_wreg = 3; m_reg_we = 1; cycle();
    stall = 1;
    for (int i = 0; i < 3; i++) begin rand_fields(); cycle(); end
    flush = 1; cycle();
    stall = 0; flush = 0;

    // Non-halting syscall, then flush colliding with a halting syscall
    set_idle(); m_valid = 1; m_order = 32'h0000000C; m_v0 = 32'd4; cycle();
    m_v0 = 32'd10; flush = 1; cycle(); flush = 0;
    // Halting syscall with enables requested, then ignored loads
    m_reg_we = 1; m_hilo_we = 1; cycle();
    for (int i = 0; i < 4; i++) begin rand_fields(); cycle(); end
    set_idle(); rst = 1; cycle(); rst = 0;

`ifdef MEM_WB_RETIRE_CNT_EN
    // Counter wrap via backdoor preload
    dut.r_retire_cnt = 32'hFFFFFFFF;
    model.cnt = 32'hFFFFFFFF;
    rand_fields(); m_valid = 1; m_order = 32'h00000021; cycle();
    rand_fields(); cycle();
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      rst   = ($urandom_range(63) == 0);
      stall = ($urandom_range(3) == 0);
      flush = ($urandom_range(7) == 0);
      if ($urandom_range(39) == 0) begin
        m_order = 32'h0000000C; m_v0 = 32'd10; m_valid = 1;
      end
      if (model.halted && $urandom_range(7) == 0) rst = 1;
      cycle();
    end

    set_idle();
    @(negedge clk); @(negedge clk);
    done = 1'b1;
    chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mem_wb_stage
`default_nettype wire
